// File: rtl/mod_mul_ctrl_if.sv
// Stream bundle around mod_mul_ctrl: operand inputs, modulo-core initiator side, result output.
// The slave modport is the multiplier block; master is its surrounding environment.
interface mod_mul_ctrl_if #(
    parameter int SIZE = 128
);
    localparam int HALF = SIZE / 2;

    logic [HALF-1:0] input_a_tdata;
    logic            input_a_tvalid;
    logic            input_a_tready;
    logic [HALF-1:0] input_b_tdata;
    logic            input_b_tvalid;
    logic            input_b_tready;
    logic [HALF-1:0] input_modulus_tdata;
    logic            input_modulus_tvalid;
    logic            input_modulus_tready;

    logic [SIZE-1:0] mod_dividen_tdata;
    logic            mod_dividen_tvalid;
    logic            mod_dividen_tready;
    logic [SIZE-1:0] mod_divisor_tdata;
    logic            mod_divisor_tvalid;
    logic            mod_divisor_tready;
    logic [SIZE-1:0] mod_result_tdata;
    logic            mod_result_tvalid;
    logic            mod_result_tready;

    logic [HALF-1:0] output_tdata;
    logic            output_tvalid;
    logic            output_tready;

    modport slave (
        input  input_a_tdata, input_a_tvalid,
        output input_a_tready,
        input  input_b_tdata, input_b_tvalid,
        output input_b_tready,
        input  input_modulus_tdata, input_modulus_tvalid,
        output input_modulus_tready,
        output mod_dividen_tdata, mod_dividen_tvalid,
        input  mod_dividen_tready,
        output mod_divisor_tdata, mod_divisor_tvalid,
        input  mod_divisor_tready,
        input  mod_result_tdata, mod_result_tvalid,
        output mod_result_tready,
        output output_tdata, output_tvalid,
        input  output_tready
    );

    modport master (
        output input_a_tdata, input_a_tvalid,
        input  input_a_tready,
        output input_b_tdata, input_b_tvalid,
        input  input_b_tready,
        output input_modulus_tdata, input_modulus_tvalid,
        input  input_modulus_tready,
        input  mod_dividen_tdata, mod_dividen_tvalid,
        output mod_dividen_tready,
        input  mod_divisor_tdata, mod_divisor_tvalid,
        output mod_divisor_tready,
        output mod_result_tdata, mod_result_tvalid,
        input  mod_result_tready,
        input  output_tdata, output_tvalid,
        output output_tready
    );
endinterface

// File: rtl/mod_mul_ctrl.sv
// Modular multiplier front-end: captures a, b, n, forms a*b by shift-add, hands (p, n)
// to the external modulo core and returns the remainder on its own output stream.
module mod_mul_ctrl #(
    parameter int SIZE = 128
) (
    input  logic          clk,
    input  logic          rst,
    mod_mul_ctrl_if.slave bus
);
    localparam int HALF = SIZE / 2;
    localparam int CW   = $clog2(HALF) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_SEND,
        S_WAIT,
        S_ZERO,
        S_OUT
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_have_a;
    logic            r_have_b;
    logic            r_have_n;
    logic [SIZE-1:0] r_mcand;
    logic [HALF-1:0] r_mplier;
    logic [HALF-1:0] r_n;
    logic [SIZE-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_div_pend;
    logic            r_dvs_pend;
    logic [HALF-1:0] r_out;

    logic            w_a_ready;
    logic            w_b_ready;
    logic            w_n_ready;
    logic            w_div_valid;
    logic            w_dvs_valid;
    logic            w_res_ready;
    logic            w_out_valid;

    logic            w_hs_a;
    logic            w_hs_b;
    logic            w_hs_n;
    logic            w_hs_div;
    logic            w_hs_dvs;
    logic            w_hs_res;
    logic            w_hs_out;

    logic            w_all_captured;
    logic [HALF-1:0] w_n_val;
    logic            w_unused;

    // In IDLE an uncaptured operand's ready is 1, so its valid alone means it lands this edge.
    assign w_all_captured = (r_have_a | bus.input_a_tvalid) &
                            (r_have_b | bus.input_b_tvalid) &
                            (r_have_n | bus.input_modulus_tvalid);
    assign w_n_val        = r_have_n ? r_n : bus.input_modulus_tdata;

    always_comb begin
        w_next      = r_state;
        w_a_ready   = 1'b0;
        w_b_ready   = 1'b0;
        w_n_ready   = 1'b0;
        w_div_valid = 1'b0;
        w_dvs_valid = 1'b0;
        w_res_ready = 1'b0;
        w_out_valid = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_a_ready = ~r_have_a;
                w_b_ready = ~r_have_b;
                w_n_ready = ~r_have_n;
                if (w_all_captured) begin
                    w_next = (w_n_val == '0) ? S_ZERO : S_MUL;
                end
            end
            S_MUL: begin
                if (r_cnt == CW'(HALF - 1)) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                w_div_valid = r_div_pend;
                w_dvs_valid = r_dvs_pend;
                if ((~r_div_pend | bus.mod_dividen_tready) &&
                    (~r_dvs_pend | bus.mod_divisor_tready)) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_res_ready = 1'b1;
                if (bus.mod_result_tvalid) begin
                    w_next = S_OUT;
                end
            end
            S_ZERO: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (bus.output_tready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (rst) begin
            w_a_ready   = 1'b0;
            w_b_ready   = 1'b0;
            w_n_ready   = 1'b0;
            w_div_valid = 1'b0;
            w_dvs_valid = 1'b0;
            w_res_ready = 1'b0;
            w_out_valid = 1'b0;
        end
    end

    assign w_hs_a   = w_a_ready & bus.input_a_tvalid;
    assign w_hs_b   = w_b_ready & bus.input_b_tvalid;
    assign w_hs_n   = w_n_ready & bus.input_modulus_tvalid;
    assign w_hs_div = w_div_valid & bus.mod_dividen_tready;
    assign w_hs_dvs = w_dvs_valid & bus.mod_divisor_tready;
    assign w_hs_res = w_res_ready & bus.mod_result_tvalid;
    assign w_hs_out = w_out_valid & bus.output_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_have_a   <= 1'b0;
            r_have_b   <= 1'b0;
            r_have_n   <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_n        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_div_pend <= 1'b0;
            r_dvs_pend <= 1'b0;
            r_out      <= '0;
        end else begin
            r_state <= w_next;

            if (w_hs_a) begin
                r_mcand  <= SIZE'(bus.input_a_tdata);
                r_have_a <= 1'b1;
            end
            if (w_hs_b) begin
                r_mplier <= bus.input_b_tdata;
                r_have_b <= 1'b1;
            end
            if (w_hs_n) begin
                r_n      <= bus.input_modulus_tdata;
                r_have_n <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                S_MUL: begin
                    // Multiplicand shifts left as the multiplier shifts right: bit i adds a<<i.
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_next == S_SEND) begin
                        r_div_pend <= 1'b1;
                        r_dvs_pend <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_hs_div) begin
                        r_div_pend <= 1'b0;
                    end
                    if (w_hs_dvs) begin
                        r_dvs_pend <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (w_hs_res) begin
                        r_out <= bus.mod_result_tdata[HALF-1:0];
                    end
                end
                S_ZERO: begin
                    r_out <= '0;
                end
                S_OUT: begin
                    if (w_hs_out) begin
                        r_have_a <= 1'b0;
                        r_have_b <= 1'b0;
                        r_have_n <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.input_a_tready       = w_a_ready;
    assign bus.input_b_tready       = w_b_ready;
    assign bus.input_modulus_tready = w_n_ready;
    assign bus.mod_dividen_tdata    = r_acc;
    assign bus.mod_dividen_tvalid   = w_div_valid;
    assign bus.mod_divisor_tdata    = SIZE'(r_n);
    assign bus.mod_divisor_tvalid   = w_dvs_valid;
    assign bus.mod_result_tready    = w_res_ready;
    assign bus.output_tdata         = r_out;
    assign bus.output_tvalid        = w_out_valid;

    // A valid remainder is below n, so the upper half of the result word carries nothing.
    assign w_unused = ^bus.mod_result_tdata[SIZE-1:HALF];
endmodule

// File: tb/tb_mod_mul_ctrl.sv
// Directed vector bench for mod_mul_ctrl with a behavioural modulo core on the initiator side.
module tb_mod_mul_ctrl;
    localparam int SIZE = 128;
    localparam int HALF = SIZE / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_mul_ctrl_if #(.SIZE(SIZE)) bus ();

    mod_mul_ctrl #(.SIZE(SIZE)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [HALF-1:0] a;
        logic [HALF-1:0] b;
        logic [HALF-1:0] n;
        logic [SIZE-1:0] p;
        logic [HALF-1:0] r;
        int              da;
        int              db;
        int              dn;
        int              div_stall;
        int              out_stall;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic quiet_inputs();
        bus.input_a_tvalid       = 1'b0;
        bus.input_b_tvalid       = 1'b0;
        bus.input_modulus_tvalid = 1'b0;
        bus.input_a_tdata        = '0;
        bus.input_b_tdata        = '0;
        bus.input_modulus_tdata  = '0;
        bus.mod_dividen_tready   = 1'b1;
        bus.mod_divisor_tready   = 1'b1;
        bus.mod_result_tvalid    = 1'b0;
        bus.mod_result_tdata     = '0;
        bus.output_tready        = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        quiet_inputs();
        rst = 1'b1;
        #1;
        chk({tag, "_readys_in_rst"},
            SIZE'({bus.input_a_tready, bus.input_b_tready, bus.input_modulus_tready, bus.mod_result_tready}), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk({tag, "_valids_after_rst"},
            SIZE'({bus.mod_dividen_tvalid, bus.mod_divisor_tvalid, bus.output_tvalid}), '0);
        chk({tag, "_out_data_after_rst"}, SIZE'(bus.output_tdata), '0);
    endtask

    // abort_mode: 0 run to completion, 1 reset 10 cycles into MUL, 2 reset on first SEND cycle
    task automatic run_op(input string tag, input vec_t v, input int abort_mode);
        logic            a_done = 1'b0, b_done = 1'b0, n_done = 1'b0;
        logic            got_div = 1'b0, got_dvs = 1'b0, res_taken = 1'b0;
        logic            saw_div = 1'b0, saw_dvs = 1'b0, done = 1'b0;
        logic [SIZE-1:0] div_val = '0, dvs_val = '0, div_first = '0;
        logic [HALF-1:0] out_data = '1, out_first = '0;
        int              cap_k = -1, div_first_k = -1, div_hs_k = -1, dvs_hs_k = -1;
        int              div_cycles = 0, out_cycles = 0;
        int              rdy_viol = 0, stab_viol = 0, wait_viol = 0;

        for (int k = 0; k < 600 && !done; k++) begin
            bus.input_a_tvalid       = !a_done && (k >= v.da);
            bus.input_a_tdata        = v.a;
            bus.input_b_tvalid       = !b_done && (k >= v.db);
            bus.input_b_tdata        = v.b;
            bus.input_modulus_tvalid = !n_done && (k >= v.dn);
            bus.input_modulus_tdata  = v.n;
            bus.mod_dividen_tready   = (div_cycles >= v.div_stall);
            bus.mod_divisor_tready   = 1'b1;
            bus.mod_result_tvalid    = got_div && got_dvs && !res_taken;
            bus.mod_result_tdata     = (got_div && got_dvs && dvs_val != '0) ? div_val % dvs_val : '0;
            bus.output_tready        = (out_cycles >= v.out_stall);
            #1;

            if ((abort_mode == 1 && cap_k >= 0 && k == cap_k + 10) ||
                (abort_mode == 2 && bus.mod_dividen_tvalid)) begin
                do_reset(tag);
                return;
            end

            if (bus.input_a_tready !== !a_done) rdy_viol++;
            if (bus.input_b_tready !== !b_done) rdy_viol++;
            if (bus.input_modulus_tready !== !n_done) rdy_viol++;
            if (bus.mod_result_tready && !got_div) wait_viol++;
            if (bus.mod_result_tready && !got_dvs) wait_viol++;

            if (bus.mod_dividen_tvalid) begin
                if (!saw_div) begin
                    saw_div     = 1'b1;
                    div_first_k = k;
                    div_first   = bus.mod_dividen_tdata;
                end else if (bus.mod_dividen_tdata !== div_first) begin
                    stab_viol++;
                end
                div_cycles++;
                if (bus.mod_dividen_tready) begin
                    got_div  = 1'b1;
                    div_val  = bus.mod_dividen_tdata;
                    div_hs_k = k;
                end
            end
            if (bus.mod_divisor_tvalid) begin
                saw_dvs = 1'b1;
                if (bus.mod_divisor_tready) begin
                    got_dvs  = 1'b1;
                    dvs_val  = bus.mod_divisor_tdata;
                    dvs_hs_k = k;
                end
            end
            if (bus.mod_result_tvalid && bus.mod_result_tready) res_taken = 1'b1;

            if (bus.output_tvalid) begin
                if (out_cycles == 0) out_first = bus.output_tdata;
                else if (bus.output_tdata !== out_first) stab_viol++;
                out_cycles++;
                if (bus.output_tready) begin
                    out_data = bus.output_tdata;
                    done     = 1'b1;
                end
            end

            if (bus.input_a_tvalid && bus.input_a_tready) a_done = 1'b1;
            if (bus.input_b_tvalid && bus.input_b_tready) b_done = 1'b1;
            if (bus.input_modulus_tvalid && bus.input_modulus_tready) n_done = 1'b1;
            if (cap_k < 0 && a_done && b_done && n_done) cap_k = k;

            @(posedge clk);
            #1;
        end
        quiet_inputs();

        chk({tag, "_completed"}, SIZE'(done), 1);
        if (v.n != '0) begin
            chk({tag, "_dividend"}, div_val, v.p);
            chk({tag, "_divisor"}, dvs_val, SIZE'(v.n));
            chk({tag, "_latency"}, SIZE'(div_first_k - cap_k), HALF + 1);
        end else begin
            chk({tag, "_no_core_txn"}, SIZE'({saw_div, saw_dvs}), '0);
        end
        chk({tag, "_output"}, SIZE'(out_data), SIZE'(v.r));
        chk({tag, "_ready_rule"}, SIZE'(rdy_viol), 0);
        chk({tag, "_stable"}, SIZE'(stab_viol), 0);
        chk({tag, "_wait_order"}, SIZE'(wait_viol), 0);
        if (v.div_stall > 0) begin
            chk({tag, "_divisor_first"}, SIZE'(dvs_hs_k < div_hs_k), 1);
            chk({tag, "_stall_len"}, SIZE'(div_hs_k - div_first_k), SIZE'(v.div_stall));
        end
    endtask

    initial begin
        vec_t vs;

        vecs[0] = '{64'd12345, 64'd6789, 64'd1000, 128'd83810205, 64'd205, 0, 0, 0, 0, 0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64'd5, 0, 0, 0, 0, 0};
        vecs[2] = '{64'd7, 64'd5, 64'd3, 128'd35, 64'd2, 7, 3, 0, 0, 0};
        vecs[3] = '{64'd12345, 64'd6789, 64'd1000, 128'd83810205, 64'd205, 0, 0, 0, 5, 3};
        vecs[4] = '{64'd9, 64'd9, 64'd0, 128'd0, 64'd0, 0, 0, 0, 0, 0};
        vecs[5] = '{64'd0, 64'd123, 64'd7, 128'd0, 64'd0, 0, 0, 0, 0, 0};
        vecs[6] = '{64'd2000, 64'd3, 64'd7, 128'd6000, 64'd1, 2, 0, 1, 0, 0};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'h1_FFFF_FFFF_FFFF_FFFE, 64'd0, 0, 0, 0, 0, 0};
        vecs[8] = '{64'd1, 64'd1, 64'd1, 128'd1, 64'd0, 0, 0, 0, 2, 1};

        rst = 1'b1;
        quiet_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valids", SIZE'({bus.mod_dividen_tvalid, bus.mod_divisor_tvalid, bus.output_tvalid}), '0);
        chk("reset_readys",
            SIZE'({bus.input_a_tready, bus.input_b_tready, bus.input_modulus_tready, bus.mod_result_tready}), '0);
        chk("reset_out_data", SIZE'(bus.output_tdata), '0);
        rst = 1'b0;
        #1;
        chk("idle_readys", SIZE'({bus.input_a_tready, bus.input_b_tready, bus.input_modulus_tready}), 3'b111);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("v%0d", i), vecs[i], 0);
        end

        run_op("abort_mul", vecs[0], 1);
        vs           = vecs[0];
        vs.div_stall = 4;
        run_op("abort_send", vs, 2);
        run_op("after_abort", vecs[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
